mine_layer: RTL and testbench
=============================

MINE_LAYER -- requirements
Module: mine_layer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the board columns.
REQ-002 The block SHALL have parameter HEIGHT, default 8, giving the board rows.
REQ-003 The block SHALL have parameter LFSR_W, default 16, giving the LFSR width (≥ XW+YW, where XW=$clog2(WIDTH), YW=$clog2(HEIGHT)).
REQ-004 The block SHALL have port clk, input, 1, clock.
REQ-005 The block SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1, one-cycle request to lay mines; accepted only in IDLE.
REQ-007 The block SHALL have port seed, input, LFSR_W, LFSR load value sampled on accepted start.
REQ-008 The block SHALL have port num_mines, input, XW+YW+1, requested mine count sampled on accepted start.
REQ-009 The block SHALL have ports safe_x / safe_y, inputs, XW / YW, the cell that must stay mine-free (first click); sampled on start.
REQ-010 The block SHALL have ports rd_x / rd_y, outputs, XW / YW, read address to the mine-map board.
REQ-011 The block SHALL have port rd_value, input, 1, combinational mine-map read data (1 = mine).
REQ-012 The block SHALL have ports wr_x / wr_y, outputs, XW / YW, target cell shared by mine write and neighbour increment.
REQ-013 The block SHALL have port mine_wr_en, output, 1, write strobe to the mine-map board; written value is always 1.
REQ-014 The block SHALL have port cnt_inc_adjacent, output, 1, increment-neighbours strobe to the count board.
REQ-015 The block SHALL have port busy, output, 1, high from the cycle after start acceptance until done.
REQ-016 The block SHALL have port done, output, 1, one-cycle pulse when placement finishes.

Function
REQ-017 The FSM SHALL have states IDLE, PICK, CHECK, WRITE, INC, FINISH.
REQ-018 IDLE SHALL go to PICK when start=1: load LFSR with seed (0x0001 if seed==0), load target = min(num_mines, WIDTH*HEIGHT-1), and clear the placed counter.
REQ-019 If target==0, IDLE SHALL go directly to FINISH instead.
REQ-020 PICK SHALL advance the LFSR one step (Galois, taps x^16+x^14+x^13+x^11+1 for LFSR_W=16) and register cand_x=lfsr[XW-1:0], cand_y=lfsr[XW+YW-1:XW].
REQ-021 CHECK SHALL drive rd_x/rd_y=cand, then go to PICK when cand_x≥WIDTH, cand_y≥HEIGHT, cand==safe, or rd_value==1; otherwise it SHALL go to WRITE.
REQ-022 WRITE SHALL assert mine_wr_en for exactly one cycle with wr_x/wr_y=cand.
REQ-023 INC SHALL assert cnt_inc_adjacent for exactly one cycle with wr_x/wr_y=cand, then increment placed.
REQ-024 After INC, the FSM SHALL go to FINISH if placed==target, else to PICK.
REQ-025 FINISH SHALL assert done for one cycle, drop busy, and return to IDLE.
REQ-026 mine_wr_en and cnt_inc_adjacent SHALL never be asserted in the same cycle.
REQ-027 wr_x/wr_y SHALL be held stable across WRITE and INC.
REQ-028 Each accepted mine SHALL cost 4 cycles (PICK, CHECK, WRITE, INC); each rejection SHALL cost 2 cycles.
REQ-029 start SHALL be ignored while busy.
REQ-030 The safe cell SHALL never receive mine_wr_en.

Reset
REQ-031 Asserting reset SHALL force IDLE immediately, abandoning any placement, with no done pulse.
REQ-032 Reset values SHALL be: mine_wr_en=0, cnt_inc_adjacent=0, busy=0, done=0, rd_x/rd_y/wr_x/wr_y=0, lfsr=0x0001, placed=0, target=0.
REQ-033 The same reset SHALL be applied to both board instances, so the boards and this block clear together.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the LFSR tap constant, and the default LFSR seed.
REQ-035 The block SHALL contain one sub-module, lfsr_galois (parameterised width/taps, with load and step controls).
REQ-036 The block SHALL instantiate no board; it connects to two external board instances: mine map (busWidth 1) and counts (busWidth 4).

Verification
REQ-037 The bench SHALL apply seed=0xACE1, num_mines=10, safe=(3,3) and check: done after ≥40 cycles, exactly 10 mine_wr_en pulses, no duplicate cell, (3,3) never written.
REQ-038 The bench SHALL apply num_mines=0 and check: done 2 cycles after start, with no write or increment strobes.
REQ-039 The bench SHALL apply num_mines=64 on an 8x8 board and check: target clamps to 63, and all cells except safe become mines.
REQ-040 The bench SHALL drive a board model, then check every non-mine count cell equals its neighbouring-mine count, including corners (0,0) and (7,7).
REQ-041 The bench SHALL assert reset in the cycle after the 3rd mine_wr_en and check: outputs reach reset values at once, no done pulse, and a new start then completes normally.
REQ-042 The bench SHALL pulse start again while busy and check: it is ignored, the mine total is unchanged, and exactly one done pulse occurs.

Source files
------------

// File: rtl/mine_layer_pkg.sv
// Shared types and constants for the mine placement block.
// FSM encoding plus LFSR polynomial and default seed.
package mine_layer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    CHECK,
    WRITE,
    INC,
    FINISH
  } state_t;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

endpackage

// File: rtl/mine_layer_lfsr.sv
// Galois LFSR with synchronous load and step.
// Exposes only the low PW bits of the next state.
module lfsr_galois #(
  parameter int           W    = 16,
  parameter int           PW   = 6,
  parameter logic [W-1:0] TAPS = W'(16'hB400),
  parameter logic [W-1:0] INIT = W'(1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  load_val,
  output logic [PW-1:0] pick
);

  logic [W-1:0] q;
  logic [W-1:0] nxt;

  assign nxt  = {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : '0);
  assign pick = nxt[PW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= INIT;
    else if (load)
      q <= load_val;
    else if (step)
      q <= nxt;
  end

endmodule

// File: rtl/mine_layer.sv
// Random mine placement driving external mine-map and count boards.
// Keeps the first-click cell clear and never writes a cell twice.
module mine_layer
  import mine_layer_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int HEIGHT = 8,
  parameter  int LFSR_W = 16,
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [XW+YW:0]    num_mines,
  input  logic [XW-1:0]     safe_x,
  input  logic [YW-1:0]     safe_y,
  output logic [XW-1:0]     rd_x,
  output logic [YW-1:0]     rd_y,
  input  logic              rd_value,
  output logic [XW-1:0]     wr_x,
  output logic [YW-1:0]     wr_y,
  output logic              mine_wr_en,
  output logic              cnt_inc_adjacent,
  output logic              busy,
  output logic              done
);

  localparam int CW = XW + YW + 1;
  localparam logic [CW-1:0] MAXM = CW'(WIDTH * HEIGHT - 1);

  state_t state, nstate;

  logic [XW-1:0] cand_x, safe_xq;
  logic [YW-1:0] cand_y, safe_yq;
  logic [CW-1:0] target, placed, clamp;
  logic [XW+YW-1:0] pick;
  logic [LFSR_W-1:0] load_val;
  logic accept, reject;

  assign accept   = (state == IDLE) && start;
  assign clamp    = (num_mines > MAXM) ? MAXM : num_mines;
  assign load_val = (seed == '0) ? LFSR_W'(LFSR_SEED) : seed;

  lfsr_galois #(
    .W    (LFSR_W),
    .PW   (XW + YW),
    .TAPS (LFSR_W'(LFSR_TAPS)),
    .INIT (LFSR_W'(LFSR_SEED))
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (state == PICK),
    .load_val (load_val),
    .pick     (pick)
  );

  assign reject = (int'(cand_x) >= WIDTH)
               || (int'(cand_y) >= HEIGHT)
               || (cand_x == safe_xq && cand_y == safe_yq)
               || rd_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_x  <= '0;
      cand_y  <= '0;
      safe_xq <= '0;
      safe_yq <= '0;
      target  <= '0;
      placed  <= '0;
    end else begin
      if (accept) begin
        target  <= clamp;
        placed  <= '0;
        safe_xq <= safe_x;
        safe_yq <= safe_y;
      end
      if (state == PICK) begin
        cand_x <= pick[XW-1:0];
        cand_y <= pick[XW+YW-1:XW];
      end
      if (state == INC)
        placed <= placed + CW'(1);
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (start)
          nstate = (clamp == '0) ? FINISH : PICK;
      PICK:   nstate = CHECK;
      CHECK:  nstate = reject ? PICK : WRITE;
      WRITE:  nstate = INC;
      INC:
        nstate = (placed + CW'(1) == target) ? FINISH : PICK;
      FINISH: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Candidate only moves in PICK, so wr stays put across WRITE/INC
  assign rd_x = cand_x;
  assign rd_y = cand_y;
  assign wr_x = cand_x;
  assign wr_y = cand_y;

  assign mine_wr_en       = (state == WRITE);
  assign cnt_inc_adjacent = (state == INC);
  assign done             = (state == FINISH);
  assign busy             = (state == PICK) || (state == CHECK)
                         || (state == WRITE) || (state == INC);

endmodule

// File: tb/tb_mine_layer.sv
// Bench for mine_layer: board models plus table-driven runs.
// Extra sequences cover mid-run reset and start while busy.
module tb_mine_layer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [6:0]  num_mines = '0;
  logic [2:0]  safe_x = '0;
  logic [2:0]  safe_y = '0;
  logic [2:0]  rd_x, rd_y, wr_x, wr_y;
  logic        rd_value;
  logic        mine_wr_en, cnt_inc_adjacent, busy, done;

  always #5 clk = ~clk;

  mine_layer #(.WIDTH(8), .HEIGHT(8), .LFSR_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .seed             (seed),
    .num_mines        (num_mines),
    .safe_x           (safe_x),
    .safe_y           (safe_y),
    .rd_x             (rd_x),
    .rd_y             (rd_y),
    .rd_value         (rd_value),
    .wr_x             (wr_x),
    .wr_y             (wr_y),
    .mine_wr_en       (mine_wr_en),
    .cnt_inc_adjacent (cnt_inc_adjacent),
    .busy             (busy),
    .done             (done)
  );

  logic       mine [64];
  logic [3:0] cnt  [64];
  logic [5:0] last_w;
  logic       have_w;
  int wr_cnt = 0;
  int done_cnt = 0;
  int mon_err = 0;
  int passed = 0;
  int total = 0;

  assign rd_value = mine[{rd_y, rd_x}];

  // Mine-map and count boards share the block's reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        mine[i] <= 1'b0;
        cnt[i]  <= 4'd0;
      end
      have_w <= 1'b0;
    end else begin
      if (mine_wr_en && cnt_inc_adjacent) mon_err++;
      if (mine_wr_en) begin
        if (mine[{wr_y, wr_x}]) mon_err++;
        if (wr_x == safe_x && wr_y == safe_y) mon_err++;
        mine[{wr_y, wr_x}] <= 1'b1;
        last_w <= {wr_y, wr_x};
        have_w <= 1'b1;
        wr_cnt++;
      end
      if (cnt_inc_adjacent) begin
        if (!have_w || last_w != {wr_y, wr_x}) mon_err++;
        have_w <= 1'b0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            nx = int'(wr_x) + dx;
            ny = int'(wr_y) + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
              cnt[ny*8+nx] <= cnt[ny*8+nx] + 4'd1;
          end
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int nb(input int x, input int y);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < 8
            && y+dy >= 0 && y+dy < 8 && mine[(y+dy)*8+x+dx])
          n++;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [6:0]  n;
    logic [2:0]  sx;
    logic [2:0]  sy;
    int          exp;
    int          restart;
  } vec_t;

  task automatic run(input vec_t v);
    int cyc, w0, d0, e0, bad, tot;
    logic got, busy2;
    w0 = wr_cnt; d0 = done_cnt; e0 = mon_err;
    got = 1'b0; busy2 = 1'b0;
    @(negedge clk);
    seed = v.seed; num_mines = v.n;
    safe_x = v.sx; safe_y = v.sy;
    start = 1'b1;
    cyc = 1;
    while (cyc < 20000 && !got) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 2) busy2 = busy;
      if (v.restart != 0 && cyc == v.restart) begin
        start = 1'b1;
        seed = 16'h1111;
        num_mines = 7'd40;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 1);
    chk("busy_after_start", 32'(busy2), 32'(v.exp != 0));
    chk("min_cycles", 32'(cyc >= 4*v.exp + 2), 1);
    chk("cycle_parity", 32'((cyc - 4*v.exp - 2) % 2), 0);
    if (v.exp == 0) chk("zero_latency", 32'(cyc), 2);
    @(negedge clk);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    chk("mine_writes", 32'(wr_cnt - w0), 32'(v.exp));
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("monitor", 32'(mon_err - e0), 0);
    chk("safe_clear", 32'(mine[{v.sy, v.sx}]), 0);
    bad = 0; tot = 0;
    for (int i = 0; i < 64; i++) begin
      if (mine[i]) tot++;
      else if (int'(cnt[i]) != nb(i % 8, i / 8)) bad++;
    end
    chk("board_mines", 32'(tot), 32'(v.exp));
    chk("count_cells", 32'(bad), 0);
    chk("cnt_00", mine[0] ? 0 : 32'(cnt[0]), mine[0] ? 0 : 32'(nb(0, 0)));
    chk("cnt_77", mine[63] ? 0 : 32'(cnt[63]), mine[63] ? 0 : 32'(nb(7, 7)));
  endtask

  vec_t vecs[7];

  initial begin
    int k, d0;
    vecs[0] = '{16'hACE1, 7'd10,  3'd3, 3'd3, 10, 0};
    vecs[1] = '{16'h0000, 7'd0,   3'd5, 3'd2, 0,  0};
    vecs[2] = '{16'h1234, 7'd64,  3'd7, 3'd7, 63, 0};
    vecs[3] = '{16'h0000, 7'd5,   3'd0, 3'd0, 5,  0};
    vecs[4] = '{16'hBEEF, 7'd100, 3'd0, 3'd7, 63, 0};
    vecs[5] = '{16'h5A5A, 7'd10,  3'd4, 3'd4, 10, 6};
    vecs[6] = '{16'hC0DE, 7'd1,   3'd7, 3'd0, 1,  0};

    #1;
    chk("reset_outputs",
        32'({busy, mine_wr_en, cnt_inc_adjacent, done, rd_x, rd_y, wr_x, wr_y}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_reset();
      run(vecs[i]);
    end

    // Reset in the cycle following the third mine write
    do_reset();
    @(negedge clk);
    seed = 16'hACE1; num_mines = 7'd10;
    safe_x = 3'd3; safe_y = 3'd3;
    start = 1'b1;
    k = 0;
    for (int c = 0; c < 2000 && k < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mine_wr_en) k++;
    end
    chk("third_write_seen", 32'(k), 3);
    @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("midrun_reset_outputs",
        32'({busy, mine_wr_en, cnt_inc_adjacent, done, rd_x, rd_y, wr_x, wr_y}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_reset_no_done", 32'(done_cnt - d0), 0);
    chk("midrun_reset_idle", 32'(busy), 0);
    run(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
